// File: rtl/axi_copy_pkg.sv
// axi_copy_pkg
//   Shared definitions for the AXI4 copy master: FSM state encodings, fixed
//   AXI attribute values and the burst-length helper that keeps every burst
//   inside one 4KB page on both the source and destination side.
package axi_copy_pkg;

  // FSM state encodings
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_AR   = 3'd1;
  localparam logic [2:0] ST_R    = 3'd2;
  localparam logic [2:0] ST_AW   = 3'd3;
  localparam logic [2:0] ST_W    = 3'd4;
  localparam logic [2:0] ST_B    = 3'd5;
  localparam logic [2:0] ST_DONE = 3'd6;

  // Fixed AXI attributes
  localparam logic [1:0] BURST_INCR    = 2'b01;
  localparam logic [2:0] SIZE_4B       = 3'd2;
  localparam logic [1:0] RESP_OKAY     = 2'b00;
  localparam logic [3:0] CACHE_DEFAULT = 4'b0011;

  // Address window of the DDR behind the memory subsystem
  localparam logic [31:0] DDR_MASK = 32'h07ff_ffff;

  // Words left before the next 4KB boundary, given the low 12 address bits.
  function automatic logic [15:0] page_room(input logic [11:0] offs);
    return 16'((13'd4096 - {1'b0, offs}) >> 2);
  endfunction

  // min(remaining, max_beats, source page room, destination page room)
  function automatic logic [8:0] burst_len(input logic [15:0] rem,
                                           input logic [11:0] src_offs,
                                           input logic [11:0] dst_offs,
                                           input logic [15:0] max_beats);
    logic [15:0] lim;
    lim = rem;
    if (max_beats < lim) lim = max_beats;
    if (page_room(src_offs) < lim) lim = page_room(src_offs);
    if (page_room(dst_offs) < lim) lim = page_room(dst_offs);
    return 9'(lim);
  endfunction

endpackage

// File: rtl/copy_buffer.sv
// copy_buffer
//   Simple dual-port burst buffer: one synchronous write port, one read port
//   with a registered output (data appears the cycle after rd_en). The read
//   register only updates on rd_en, so rd_data holds while the consumer stalls.
// Ports:
//   clock            clock
//   wr_en/addr/data  write port
//   rd_en/addr       read request
//   rd_data          registered read data
module copy_buffer #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clock) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/axi_copy_master.sv
// axi_copy_master
//   AXI4 initiator that copies cmd_beats 32-bit words from cmd_src to cmd_dst.
//   Each burst is read into a local buffer (AR/R) and then written back out
//   (AW/W/B). Only one AXI transaction is outstanding at any time.
// Ports:
//   clock, resetn        clock and asynchronous active-low reset
//   cmd_*                copy request (accepted only in IDLE)
//   done_valid/done_err  one-cycle completion pulse with error status
//   busy                 high whenever the FSM is not IDLE
//   m_axi_aw/w/b/ar/r    AXI4 master interface
module axi_copy_master
  import axi_copy_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ID_W      = 4,
  parameter int AXI_ID    = 0,
  parameter int MAX_BURST = 16
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [31:0]         cmd_src,
  input  logic [31:0]         cmd_dst,
  input  logic [15:0]         cmd_beats,
  output logic                done_valid,
  output logic                done_err,
  output logic                busy,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [ID_W-1:0]     m_axi_awid,
  output logic [31:0]         m_axi_awaddr,
  output logic [7:0]          m_axi_awlen,
  output logic [2:0]          m_axi_awsize,
  output logic [1:0]          m_axi_awburst,
  output logic                m_axi_awlock,
  output logic [3:0]          m_axi_awcache,
  output logic [2:0]          m_axi_awprot,
  output logic [3:0]          m_axi_awqos,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wlast,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  input  logic [ID_W-1:0]     m_axi_bid,
  input  logic [1:0]          m_axi_bresp,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  output logic [ID_W-1:0]     m_axi_arid,
  output logic [31:0]         m_axi_araddr,
  output logic [7:0]          m_axi_arlen,
  output logic [2:0]          m_axi_arsize,
  output logic [1:0]          m_axi_arburst,
  output logic                m_axi_arlock,
  output logic [3:0]          m_axi_arcache,
  output logic [2:0]          m_axi_arprot,
  output logic [3:0]          m_axi_arqos,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready,
  input  logic [ID_W-1:0]     m_axi_rid,
  input  logic [DATA_W-1:0]   m_axi_rdata,
  input  logic [1:0]          m_axi_rresp,
  input  logic                m_axi_rlast
);

  localparam int IDX_W = $clog2(MAX_BURST);

  logic [2:0]  state_reg, state_next;
  logic [31:0] src_reg, dst_reg;
  logic [15:0] remaining_reg;
  logic [8:0]  n_reg;          // beats in the current burst, 1..MAX_BURST
  logic [8:0]  beat_cnt_reg;   // beat index within R or W
  logic        err_reg;        // sticky error for the current command

  logic [8:0]  n_m1, beat_inc, n_calc;
  logic        last_beat, beat_err, misaligned;
  logic [31:0] ld_src, ld_dst;
  logic [15:0] ld_rem;

  logic             buf_rd_en;
  logic [IDX_W-1:0] buf_rd_addr;

  assign n_m1       = n_reg - 9'd1;
  assign beat_inc   = beat_cnt_reg + 9'd1;
  assign last_beat  = (beat_cnt_reg == n_m1);
  assign misaligned = (cmd_src[1:0] != 2'b00) || (cmd_dst[1:0] != 2'b00);

  // A bad response, an early rlast or a missing rlast all poison the read.
  assign beat_err = (m_axi_rresp != RESP_OKAY) || (m_axi_rlast != last_beat);

  // Values that feed the next burst: the command in IDLE, the advanced
  // pointers after a good B response. The burst length is derived from them
  // in the same cycle and then held for the whole AR..B sequence.
  always_comb begin
    ld_src = cmd_src;
    ld_dst = cmd_dst;
    ld_rem = cmd_beats;
    if (state_reg != ST_IDLE) begin
      ld_src = src_reg + {21'd0, n_reg, 2'b00};
      ld_dst = dst_reg + {21'd0, n_reg, 2'b00};
      ld_rem = remaining_reg - {7'd0, n_reg};
    end
  end

  assign n_calc = burst_len(ld_rem, ld_src[11:0], ld_dst[11:0], 16'(MAX_BURST));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (cmd_beats == 16'd0 || misaligned) state_next = ST_DONE;
          else                                  state_next = ST_AR;
        end
      end
      ST_AR: if (m_axi_arready) state_next = ST_R;
      ST_R: begin
        if (m_axi_rvalid && (m_axi_rlast || last_beat))
          state_next = (err_reg || beat_err) ? ST_DONE : ST_AW;
      end
      ST_AW: if (m_axi_awready) state_next = ST_W;
      ST_W:  if (m_axi_wready && last_beat) state_next = ST_B;
      ST_B: begin
        if (m_axi_bvalid) begin
          if (m_axi_bresp != RESP_OKAY || ld_rem == 16'd0) state_next = ST_DONE;
          else                                              state_next = ST_AR;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg     <= ST_IDLE;
      src_reg       <= '0;
      dst_reg       <= '0;
      remaining_reg <= '0;
      n_reg         <= '0;
      beat_cnt_reg  <= '0;
      err_reg       <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        ST_IDLE: begin
          if (cmd_valid) begin
            src_reg       <= cmd_src;
            dst_reg       <= cmd_dst;
            remaining_reg <= cmd_beats;
            n_reg         <= n_calc;
            err_reg       <= (cmd_beats != 16'd0) && misaligned;
          end
        end
        ST_AR: if (m_axi_arready) beat_cnt_reg <= '0;
        ST_R: begin
          if (m_axi_rvalid) begin
            beat_cnt_reg <= beat_inc;
            if (beat_err) err_reg <= 1'b1;
          end
        end
        ST_AW: if (m_axi_awready) beat_cnt_reg <= '0;
        ST_W:  if (m_axi_wready) beat_cnt_reg <= beat_inc;
        ST_B: begin
          if (m_axi_bvalid) begin
            if (m_axi_bresp != RESP_OKAY) begin
              err_reg <= 1'b1;
            end else begin
              src_reg       <= ld_src;
              dst_reg       <= ld_dst;
              remaining_reg <= ld_rem;
              n_reg         <= n_calc;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Buffer read side: word 0 is prefetched throughout AW so wvalid can rise
  // right after the AW handshake; each accepted W beat fetches the next word.
  always_comb begin
    buf_rd_en   = 1'b0;
    buf_rd_addr = '0;
    if (state_reg == ST_AW) begin
      buf_rd_en = 1'b1;
    end else if (state_reg == ST_W) begin
      buf_rd_en   = m_axi_wready && !last_beat;
      buf_rd_addr = beat_inc[IDX_W-1:0];
    end
  end

  copy_buffer #(
    .DEPTH  (MAX_BURST),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_buffer (
    .clock   (clock),
    .wr_en   ((state_reg == ST_R) && m_axi_rvalid),
    .wr_addr (beat_cnt_reg[IDX_W-1:0]),
    .wr_data (m_axi_rdata),
    .rd_en   (buf_rd_en),
    .rd_addr (buf_rd_addr),
    .rd_data (m_axi_wdata)
  );

  assign cmd_ready  = (state_reg == ST_IDLE);
  assign busy       = (state_reg != ST_IDLE);
  assign done_valid = (state_reg == ST_DONE);
  assign done_err   = (state_reg == ST_DONE) && err_reg;

  assign m_axi_arvalid = (state_reg == ST_AR);
  assign m_axi_arid    = ID_W'(AXI_ID);
  assign m_axi_araddr  = src_reg;
  assign m_axi_arlen   = n_m1[7:0];
  assign m_axi_arsize  = SIZE_4B;
  assign m_axi_arburst = BURST_INCR;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = CACHE_DEFAULT;
  assign m_axi_arprot  = 3'd0;
  assign m_axi_arqos   = 4'd0;
  assign m_axi_rready  = (state_reg == ST_R);

  assign m_axi_awvalid = (state_reg == ST_AW);
  assign m_axi_awid    = ID_W'(AXI_ID);
  assign m_axi_awaddr  = dst_reg;
  assign m_axi_awlen   = n_m1[7:0];
  assign m_axi_awsize  = SIZE_4B;
  assign m_axi_awburst = BURST_INCR;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = CACHE_DEFAULT;
  assign m_axi_awprot  = 3'd0;
  assign m_axi_awqos   = 4'd0;

  assign m_axi_wvalid  = (state_reg == ST_W);
  assign m_axi_wstrb   = '1;
  assign m_axi_wlast   = (state_reg == ST_W) && last_beat;
  assign m_axi_bready  = (state_reg == ST_B);

  // Response IDs need no checking with a single outstanding transaction.
  logic unused_ok;
  assign unused_ok = ^{m_axi_rid, m_axi_bid, n_m1[8]};

endmodule

// File: tb/tb_axi_copy_master.sv
// tb_axi_copy_master
//   Directed bench for axi_copy_master with a behavioural AXI4 slave whose
//   read data is a fixed function of the address. Logs AR/AW requests and
//   W beats, then compares them against hand-computed expectations.
module tb_axi_copy_master;

  logic        clock = 1'b0;
  logic        resetn;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_src, cmd_dst;
  logic [15:0] cmd_beats;
  logic        done_valid, done_err, busy;
  logic        m_axi_awvalid, m_axi_awready, m_axi_awlock;
  logic [3:0]  m_axi_awid, m_axi_awcache, m_axi_awqos;
  logic [31:0] m_axi_awaddr;
  logic [7:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize, m_axi_awprot;
  logic [1:0]  m_axi_awburst;
  logic        m_axi_wvalid, m_axi_wready, m_axi_wlast;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_bvalid, m_axi_bready;
  logic [3:0]  m_axi_bid;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_arvalid, m_axi_arready, m_axi_arlock;
  logic [3:0]  m_axi_arid, m_axi_arcache, m_axi_arqos;
  logic [31:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize, m_axi_arprot;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_rvalid, m_axi_rready, m_axi_rlast;
  logic [3:0]  m_axi_rid;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;

  always #5 clock = ~clock;

  axi_copy_master dut (
    .clock(clock), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_src(cmd_src),
    .cmd_dst(cmd_dst), .cmd_beats(cmd_beats),
    .done_valid(done_valid), .done_err(done_err), .busy(busy),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready), .m_axi_awid(m_axi_awid),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
    .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock), .m_axi_awcache(m_axi_awcache),
    .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_wdata(m_axi_wdata),
    .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_bid(m_axi_bid),
    .m_axi_bresp(m_axi_bresp),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready), .m_axi_arid(m_axi_arid),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock), .m_axi_arcache(m_axi_arcache),
    .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .m_axi_rid(m_axi_rid),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast)
  );

  // ---------------- bench state ----------------
  int vectors = 0;
  int miscompares = 0;

  logic        stall_en = 1'b0;
  int          r_err_beat = -1;
  logic        b_err = 1'b0;

  logic [31:0] ar_addr_q[$], aw_addr_q[$];
  logic [7:0]  ar_len_q[$],  aw_len_q[$];
  logic [31:0] wmem [logic [31:0]];
  int          w_total, wlast_err, stab_err, r_acc, done_cnt;
  logic        last_err, any_valid;

  // posedge samples
  logic        s_ar, s_r, s_aw, s_w, s_b, s_wlast;
  logic [31:0] s_araddr, s_awaddr, s_wdata;
  logic [7:0]  s_arlen, s_awlen;
  logic        hold_ar, hold_aw, hold_w, p_wlast;
  logic [31:0] p_araddr, p_awaddr, p_wdata;
  logic [7:0]  p_arlen, p_awlen;

  // slave state
  logic [31:0] r_addr, w_addr;
  int          r_left, r_beat, w_beat, w_len;
  logic        b_pend;

  function automatic logic [31:0] src_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- AXI slave model ----------------
  always begin
    @(posedge clock);
    if (!resetn) begin
      {s_ar, s_r, s_aw, s_w, s_b, hold_ar, hold_aw, hold_w} = '0;
    end else begin
      if (hold_ar && (!m_axi_arvalid || m_axi_araddr != p_araddr || m_axi_arlen != p_arlen)) stab_err++;
      if (hold_aw && (!m_axi_awvalid || m_axi_awaddr != p_awaddr || m_axi_awlen != p_awlen)) stab_err++;
      if (hold_w && (!m_axi_wvalid || m_axi_wdata != p_wdata || m_axi_wlast != p_wlast)) stab_err++;
      hold_ar = m_axi_arvalid && !m_axi_arready;
      hold_aw = m_axi_awvalid && !m_axi_awready;
      hold_w  = m_axi_wvalid && !m_axi_wready;
      p_araddr = m_axi_araddr; p_arlen = m_axi_arlen;
      p_awaddr = m_axi_awaddr; p_awlen = m_axi_awlen;
      p_wdata  = m_axi_wdata;  p_wlast = m_axi_wlast;
      s_ar = m_axi_arvalid && m_axi_arready; s_araddr = m_axi_araddr; s_arlen = m_axi_arlen;
      s_aw = m_axi_awvalid && m_axi_awready; s_awaddr = m_axi_awaddr; s_awlen = m_axi_awlen;
      s_w  = m_axi_wvalid && m_axi_wready;   s_wdata = m_axi_wdata;   s_wlast = m_axi_wlast;
      s_r  = m_axi_rvalid && m_axi_rready;
      s_b  = m_axi_bvalid && m_axi_bready;
      if (m_axi_arvalid || m_axi_awvalid || m_axi_wvalid) any_valid = 1'b1;
      if (done_valid) begin done_cnt++; last_err = done_err; end
    end
    @(negedge clock);
    if (!resetn) begin
      m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rlast = 0; m_axi_rresp = 0;
      m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0;
      r_left = 0; b_pend = 0;
    end else begin
      if (s_ar) begin
        ar_addr_q.push_back(s_araddr); ar_len_q.push_back(s_arlen);
        r_addr = s_araddr; r_left = int'(s_arlen) + 1; r_beat = 0;
      end
      if (s_r) begin r_left--; r_beat++; r_addr += 4; r_acc++; end
      if (!(m_axi_rvalid && !s_r)) begin
        if (r_left > 0 && (!stall_en || $urandom_range(0, 3) != 0)) begin
          m_axi_rvalid = 1; m_axi_rdata = src_word(r_addr);
          m_axi_rresp = (r_beat == r_err_beat) ? 2'b10 : 2'b00;
          m_axi_rlast = (r_left == 1);
        end else begin
          m_axi_rvalid = 0; m_axi_rlast = 0;
        end
      end
      if (s_aw) begin
        aw_addr_q.push_back(s_awaddr); aw_len_q.push_back(s_awlen);
        w_addr = s_awaddr; w_len = int'(s_awlen); w_beat = 0;
      end
      if (s_w) begin
        wmem[w_addr] = s_wdata;
        if (s_wlast != (w_beat == w_len)) wlast_err++;
        w_addr += 4; w_beat++; w_total++;
        if (s_wlast) b_pend = 1;
      end
      if (s_b) begin
        m_axi_bvalid = 0; b_pend = 0;
      end else if (!m_axi_bvalid && b_pend && (!stall_en || $urandom_range(0, 1) == 0)) begin
        m_axi_bvalid = 1; m_axi_bresp = b_err ? 2'b10 : 2'b00;
      end
      m_axi_arready = !stall_en || ($urandom_range(0, 2) == 0);
      m_axi_awready = !stall_en || ($urandom_range(0, 2) == 0);
      m_axi_wready  = !stall_en || ($urandom_range(0, 2) != 0);
    end
  end

  // ---------------- helpers ----------------
  task automatic clear_logs();
    ar_addr_q.delete(); ar_len_q.delete(); aw_addr_q.delete(); aw_len_q.delete();
    wmem.delete();
    w_total = 0; wlast_err = 0; stab_err = 0; r_acc = 0; done_cnt = 0;
    last_err = 1'bx; any_valid = 0;
  endtask

  task automatic run_copy(input string tag, input logic [31:0] s, input logic [31:0] d,
                          input logic [15:0] b, input int max_cycles);
    int i;
    clear_logs();
    @(negedge clock);
    cmd_valid = 1; cmd_src = s; cmd_dst = d; cmd_beats = b;
    @(negedge clock);
    cmd_valid = 0;
    for (i = 0; i < max_cycles && done_cnt == 0; i++) @(negedge clock);
    check({tag, "_done_seen"}, 32'(done_cnt != 0), 32'd1);
    repeat (4) @(negedge clock);
    check({tag, "_done_count"}, 32'(done_cnt), 32'd1);
  endtask

  task automatic check_data(input string tag, input logic [31:0] s, input logic [31:0] d,
                            input int beats);
    int bad = 0;
    for (int i = 0; i < beats; i++) begin
      logic [31:0] da;
      da = d + 32'(4 * i);
      if (!wmem.exists(da)) bad++;
      else if (wmem[da] !== src_word(s + 32'(4 * i))) bad++;
    end
    check({tag, "_data_bad_words"}, 32'(bad), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    resetn = 0; cmd_valid = 0; cmd_src = 0; cmd_dst = 0; cmd_beats = 0;
    m_axi_rid = 0; m_axi_bid = 0; m_axi_rdata = 0;
    m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rlast = 0; m_axi_rresp = 0;
    m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0;
    clear_logs();
    repeat (3) @(negedge clock);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valids", 32'({m_axi_arvalid, m_axi_awvalid, m_axi_wvalid}), 32'd0);
    check("rst_readies", 32'({m_axi_rready, m_axi_bready}), 32'd0);
    check("rst_done", 32'({done_valid, done_err}), 32'd0);
    resetn = 1;
    repeat (2) @(negedge clock);

    // basic 4-beat copy
    run_copy("t1", 32'h100, 32'h2000, 16'd4, 200);
    check("t1_ar_count", 32'(ar_addr_q.size()), 32'd1);
    check("t1_araddr", ar_addr_q[0], 32'h100);
    check("t1_arlen", 32'(ar_len_q[0]), 32'd3);
    check("t1_awaddr", aw_addr_q[0], 32'h2000);
    check("t1_awlen", 32'(aw_len_q[0]), 32'd3);
    check("t1_w_beats", 32'(w_total), 32'd4);
    check("t1_wlast_pos_errs", 32'(wlast_err), 32'd0);
    check("t1_done_err", 32'(last_err), 32'd0);
    check_data("t1", 32'h100, 32'h2000, 4);

    // 40 beats split 16/16/8
    run_copy("t2", 32'h0, 32'h1000, 16'd40, 500);
    check("t2_ar_count", 32'(ar_addr_q.size()), 32'd3);
    check("t2_arlen0", 32'(ar_len_q[0]), 32'd15);
    check("t2_arlen1", 32'(ar_len_q[1]), 32'd15);
    check("t2_arlen2", 32'(ar_len_q[2]), 32'd7);
    check("t2_araddr1", ar_addr_q[1], 32'h40);
    check("t2_araddr2", ar_addr_q[2], 32'h80);
    check("t2_awaddr1", aw_addr_q[1], 32'h1040);
    check("t2_awaddr2", aw_addr_q[2], 32'h1080);
    check("t2_awlen2", 32'(aw_len_q[2]), 32'd7);
    check("t2_w_beats", 32'(w_total), 32'd40);
    check("t2_done_err", 32'(last_err), 32'd0);
    check_data("t2", 32'h0, 32'h1000, 40);

    // 4KB boundary split on the source side
    run_copy("t3", 32'hFF8, 32'h3000, 16'd8, 300);
    check("t3_ar_count", 32'(ar_addr_q.size()), 32'd2);
    check("t3_arlen0", 32'(ar_len_q[0]), 32'd1);
    check("t3_araddr1", ar_addr_q[1], 32'h1000);
    check("t3_arlen1", 32'(ar_len_q[1]), 32'd5);
    check("t3_awaddr1", aw_addr_q[1], 32'h3008);
    check("t3_awlen0", 32'(aw_len_q[0]), 32'd1);
    check_data("t3", 32'hFF8, 32'h3000, 8);

    // random stalls on every channel
    stall_en = 1;
    run_copy("t4", 32'h4000, 32'h5000, 16'd20, 3000);
    stall_en = 0;
    check("t4_ar_count", 32'(ar_addr_q.size()), 32'd2);
    check("t4_w_beats", 32'(w_total), 32'd20);
    check("t4_stability_errs", 32'(stab_err), 32'd0);
    check("t4_wlast_pos_errs", 32'(wlast_err), 32'd0);
    check("t4_done_err", 32'(last_err), 32'd0);
    check_data("t4", 32'h4000, 32'h5000, 20);

    // SLVERR on read beat 2
    r_err_beat = 2;
    run_copy("t5", 32'h6000, 32'h7000, 16'd4, 200);
    r_err_beat = -1;
    check("t5_r_beats", 32'(r_acc), 32'd4);
    check("t5_aw_count", 32'(aw_addr_q.size()), 32'd0);
    check("t5_done_err", 32'(last_err), 32'd1);

    // SLVERR on the first write response
    b_err = 1;
    run_copy("t6", 32'h0, 32'h1000, 16'd40, 300);
    b_err = 0;
    check("t6_ar_count", 32'(ar_addr_q.size()), 32'd1);
    check("t6_done_err", 32'(last_err), 32'd1);

    // zero-length command
    run_copy("t7", 32'h100, 32'h200, 16'd0, 2);
    check("t7_done_err", 32'(last_err), 32'd0);
    check("t7_any_valid", 32'(any_valid), 32'd0);

    // misaligned source
    run_copy("t8", 32'h102, 32'h200, 16'd4, 3);
    check("t8_done_err", 32'(last_err), 32'd1);
    check("t8_any_valid", 32'(any_valid), 32'd0);

    // reset in the middle of the write phase
    begin
      int i;
      clear_logs();
      stall_en = 1;
      @(negedge clock);
      cmd_valid = 1; cmd_src = 32'h8000; cmd_dst = 32'h9000; cmd_beats = 16'd16;
      @(negedge clock);
      cmd_valid = 0;
      for (i = 0; i < 1000 && !m_axi_wvalid; i++) @(negedge clock);
      check("t9_reached_w", 32'(m_axi_wvalid), 32'd1);
      #2 resetn = 0;
      #1;
      check("t9_valids", 32'({m_axi_arvalid, m_axi_awvalid, m_axi_wvalid}), 32'd0);
      check("t9_busy", 32'(busy), 32'd0);
      check("t9_cmd_ready", 32'(cmd_ready), 32'd1);
      check("t9_done", 32'(done_valid), 32'd0);
      stall_en = 0;
      repeat (2) @(negedge clock);
      resetn = 1;
      repeat (2) @(negedge clock);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axi_copy_master.md
Name: axi_copy_master

Overview:
- AXI4 initiator (master) that copies a block of 32-bit words from a source address to a destination address in DDR.
- Issues INCR read bursts into a local burst buffer, then writes each burst back out.
- Sits between the RoCC accelerator command path and the AXI4 port of the memory subsystem, which is the slave/responder side of the same interface.

Parameters:
- DATA_W, 32: AXI data width; strobe width is DATA_W/8.
- ID_W, 4: AXI ID width.
- AXI_ID, 0: constant ID driven on AW and AR.
- MAX_BURST, 16: maximum beats per burst and buffer depth; power of two, 2..256.

Ports:
- clock  in  1  single clock for all logic
- resetn  in  1  asynchronous, active-low reset
- cmd_valid  in  1  copy request valid
- cmd_ready  out  1  high only in IDLE
- cmd_src  in  32  source byte address, 4-byte aligned
- cmd_dst  in  32  destination byte address, 4-byte aligned
- cmd_beats  in  16  number of words to copy
- done_valid  out  1  one-cycle completion pulse
- done_err  out  1  error status, valid with done_valid
- busy  out  1  high whenever state is not IDLE
- m_axi_aw{valid,ready,id,addr,len,size,burst,lock,cache,prot,qos}: AXI4 write address; valid/ready/id/addr/len/size/burst are standard AXI4 widths (addr 32, len 8, size 3, burst 2); lock 1, cache 4, prot 3, qos 4
- m_axi_w{valid,ready,data,strb,last}: AXI4 write data
- m_axi_b{valid,ready,id,resp}: AXI4 write response
- m_axi_ar{...}: same field set as AW
- m_axi_r{valid,ready,id,data,resp,last}: AXI4 read data

Behaviour:
- Reset (resetn=0, asynchronous): state IDLE; all m_axi_*valid=0; bready=0; rready=0; done_valid=0; done_err=0; busy=0; cmd_ready=1 once in IDLE.
- Constant fields:
  - size=3'd2, burst=2'b01 (INCR), lock=0, cache=4'b0011, prot=0, qos=0, id=AXI_ID.
  - wstrb is all ones.
- States: IDLE, AR, R, AW, W, B, DONE.
- IDLE:
  - On cmd_valid&&cmd_ready, latch src, dst and remaining=cmd_beats.
  - If cmd_beats==0: go to DONE with err=0, no AXI traffic.
  - If src[1:0] or dst[1:0] is nonzero: go to DONE with err=1, no AXI traffic.
  - Otherwise go to AR. arvalid asserts on the cycle after acceptance.
- Burst length n = min(remaining, MAX_BURST, (4096 - src[11:0])>>2, (4096 - dst[11:0])>>2). No burst crosses a 4KB boundary on either side. n is computed once on entry to AR and held until that burst's B completes.
- AR:
  - araddr=src, arlen=n-1.
  - Hold arvalid and all AR fields stable until arready; then go to R.
- R:
  - rready=1.
  - Each beat writes the buffer at index 0..n-1.
  - rresp!=0 sets a sticky read error.
  - On the rlast beat: with a read error go to DONE (err=1); otherwise go to AW.
  - If rlast is absent on beat n-1, still leave R after n beats. rlast early is also an error.
- AW:
  - awaddr=dst, awlen=n-1.
  - Hold until awready; then go to W.
- W:
  - wdata comes from the buffer. The first beat's read is prefetched during AW, so wvalid asserts on the cycle after the AW handshake.
  - Beats are streamed back-to-back while wready=1.
  - wvalid and wdata are held stable under backpressure.
  - wlast=1 exactly on beat n-1; after it, go to B.
- B:
  - bready=1.
  - On bvalid: bresp!=0 -> DONE with err=1.
  - Otherwise: src+=4n, dst+=4n, remaining-=n. If remaining==0 go to DONE (err=0), else go to AR.
- DONE: done_valid=1 for one cycle with done_err; next state IDLE.
- AXI rules:
  - No valid deasserts before its handshake.
  - Only one outstanding transaction exists at any time, so R and B IDs are not checked.
- Address arithmetic is 32-bit modulo 2^32, with no wrap detection.
- Reset asserted mid-transfer aborts immediately. The downstream slave is reset in the same domain.

Decomposition:
- Package axi_copy_pkg: state enum, AXI constants (BURST_INCR=2'b01, SIZE_4B=3'd2, RESP_OKAY=2'b00, CACHE_DEFAULT=4'b0011), DDR_MASK=32'h07ffffff for bench address checks.
- Sub-module copy_buffer: MAX_BURST x DATA_W simple dual-port RAM, synchronous write, registered read (1-cycle latency).

Test Plan:
- src=0x100, dst=0x2000, beats=4, zero-wait slave:
  - AR addr 0x100 len 3, then AW addr 0x2000 len 3, with W data identical to the R data.
  - wlast on the 4th beat; done_valid=1 with done_err=0.
- beats=40, MAX_BURST=16, src=0x0, dst=0x1000:
  - Three AR/AW pairs with len 15, 15, 7.
  - Addresses advance by 0x40 per burst; a single done pulse at the end.
- src=0xFF8, beats=8:
  - First burst len 1 (stops at the 4KB boundary), second burst src=0x1000 len 5.
- Random wready/awready/arready/rvalid stalls, beats=20:
  - Valids and payloads stay stable under stall; memory content matches.
  - Exactly 20 W beats.
- rresp=2'b10 on beat 2 of a 4-beat read:
  - All 4 R beats accepted, no AW issued, done_err=1.
  - bresp=2'b10 on the first burst ends with done_err=1 and no further AR.
- beats=0 -> done_valid on the 2nd cycle after acceptance with err=0 and no AXI valids; src=0x102 -> done_err=1 with no traffic.
- Reset asserted mid-W -> all valids low immediately, busy=0, cmd_ready=1.
